// File: rtl/prt_led_ctl_pkg.sv
// rtl/prt_led_ctl_pkg.sv - shared types and sizing helpers for the status-LED scheduler
package prt_led_ctl_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} prt_led_ctl_state_t;

  localparam int PRT_LED_MAX_REQ = 8;

  // One counter width serves prescaler, phase and heartbeat counters.
  function automatic int prt_cnt_width(input int a, input int b, input int c,
                                       input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/prt_led_ctl_if.sv
// rtl/prt_led_ctl_if.sv - requester/LED bus; DIM_IN present only with PRT_LED_CTL_PWM_EN
interface prt_led_ctl_if #(
  parameter int P_REQ = 4
);
  logic [P_REQ-1:0] REQ_IN;
  logic             LED_OUT;
  logic [P_REQ-1:0] GNT_OUT;
  logic             BUSY_OUT;
`ifdef PRT_LED_CTL_PWM_EN
  logic [7:0]       DIM_IN;

  modport master (output REQ_IN, output DIM_IN, input LED_OUT, input GNT_OUT, input BUSY_OUT);
  modport slave  (input REQ_IN, input DIM_IN, output LED_OUT, output GNT_OUT, output BUSY_OUT);
`else
  modport master (output REQ_IN, input LED_OUT, input GNT_OUT, input BUSY_OUT);
  modport slave  (input REQ_IN, output LED_OUT, output GNT_OUT, output BUSY_OUT);
`endif
endinterface

// File: rtl/prt_led_ctl_rr.sv
// rtl/prt_led_ctl_rr.sv - combinational round-robin pick: first set request at or after ptr
module prt_led_ctl_rr #(
  parameter int P_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [P_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [P_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  logic [PW-1:0] cand;

  // Scan from the farthest offset down so the nearest one to ptr is kept.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = P_REQ - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr) + i) % P_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    gnt = valid ? (P_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/prt_led_ctl.sv
// rtl/prt_led_ctl.sv - shared status LED: RR blink codes or heartbeat; PRT_LED_CTL_PWM_EN adds dimming
module prt_led_ctl
  import prt_led_ctl_pkg::*;
#(
  parameter int P_REQ  = 4,
  parameter int P_TICK = 1000,
  parameter int P_BEAT = 100,
  parameter int P_ON   = 2,
  parameter int P_OFF  = 2,
  parameter int P_GAP  = 8
) (
  input  logic         CLK_IN,
  input  logic         RST_IN,
  prt_led_ctl_if.slave bus
);

  localparam int CW = prt_cnt_width(P_TICK, P_BEAT, P_GAP, P_ON, P_OFF);
  localparam int PW = (P_REQ > 1) ? $clog2(P_REQ) : 1;
  localparam int NW = $clog2(P_REQ + 1);

  localparam logic [CW-1:0] TICK_MAX = CW'(P_TICK - 1);
  localparam logic [CW-1:0] BEAT_MAX = CW'(P_BEAT - 1);
  localparam logic [CW-1:0] ON_MAX   = CW'(P_ON - 1);
  localparam logic [CW-1:0] OFF_MAX  = CW'(P_OFF - 1);
  localparam logic [CW-1:0] GAP_MAX  = CW'(P_GAP - 1);
  localparam logic [PW-1:0] IDX_MAX  = PW'(P_REQ - 1);

  prt_led_ctl_state_t state_q, state_d;
  logic [CW-1:0]    pre_q, pre_d, phase_q, phase_d, hb_q, hb_d;
  logic [NW-1:0]    pulses_q, pulses_d;
  logic [PW-1:0]    ptr_q, ptr_d, idx_q, idx_d;
  logic [P_REQ-1:0] gnt_q, gnt_d;
  logic             led_q, led_d;
  logic             tick;

  logic [P_REQ-1:0] rr_gnt;
  logic [PW-1:0]    rr_idx;
  logic             rr_valid;

  prt_led_ctl_rr #(.P_REQ(P_REQ), .PW(PW)) u_rr (
    .req   (bus.REQ_IN),
    .ptr   (ptr_q),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  assign tick = (pre_q == TICK_MAX);

  always_comb begin
    pre_d    = tick ? '0 : pre_q + 1'b1;
    state_d  = state_q;
    phase_d  = phase_q;
    hb_d     = hb_q;
    pulses_d = pulses_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    led_d    = led_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          // A new grant wins over a heartbeat toggle landing on the same tick.
          if (rr_valid) begin
            gnt_d    = rr_gnt;
            idx_d    = rr_idx;
            led_d    = 1'b1;
            pulses_d = NW'(rr_idx) + NW'(1);
            phase_d  = '0;
            hb_d     = '0;
            state_d  = ON;
          end else if (hb_q == BEAT_MAX) begin
            led_d = ~led_q;
            hb_d  = '0;
          end else begin
            hb_d = hb_q + 1'b1;
          end
        end
        ON: begin
          if (phase_q == ON_MAX) begin
            led_d    = 1'b0;
            phase_d  = '0;
            pulses_d = pulses_q - 1'b1;
            state_d  = (pulses_q == NW'(1)) ? GAP : OFF;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        OFF: begin
          if (phase_q == OFF_MAX) begin
            led_d   = 1'b1;
            phase_d = '0;
            state_d = ON;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        GAP: begin
          if (phase_q == GAP_MAX) begin
            gnt_d   = '0;
            ptr_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            phase_d = '0;
            hb_d    = '0;
            state_d = IDLE;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      phase_q  <= '0;
      hb_q     <= '0;
      pulses_q <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      phase_q  <= phase_d;
      hb_q     <= hb_d;
      pulses_q <= pulses_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      led_q    <= led_d;
    end
  end

  assign bus.GNT_OUT  = gnt_q;
  assign bus.BUSY_OUT = (state_q != IDLE);

`ifdef PRT_LED_CTL_PWM_EN
  logic [7:0] pwm_q, pwm_d;

  assign pwm_d = pwm_q + 8'd1;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) pwm_q <= '0;
    else        pwm_q <= pwm_d;
  end

  // led_q is only high in ON or heartbeat-on, so gating it covers both.
  assign bus.LED_OUT = led_q & (pwm_q < bus.DIM_IN);
`else
  assign bus.LED_OUT = led_q;
`endif

endmodule

// File: tb/tb_prt_led_ctl.sv
// tb/tb_prt_led_ctl.sv - directed bench for prt_led_ctl with small tick/phase parameters
module tb_prt_led_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   edge_n;

  always #5 clk = ~clk;

  prt_led_ctl_if #(.P_REQ(4)) bus ();

  prt_led_ctl #(
    .P_REQ(4), .P_TICK(4), .P_BEAT(3), .P_ON(2), .P_OFF(1), .P_GAP(3)
  ) dut (
    .CLK_IN (clk),
    .RST_IN (rst),
    .bus    (bus)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // k-pulse code, m cycles after the grant edge: 8 on / 4 off per pulse, then off.
  function automatic logic exp_led(input int m, input int k);
    if (m < 12 * k - 4) return (m % 12) < 8;
    return 1'b0;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.REQ_IN = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.REQ_IN = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.LED_OUT !== 1'b0) begin errors++; $display("FAIL reset_led: got %b want 0", bus.LED_OUT); end
    checks++;
    if (bus.GNT_OUT !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.GNT_OUT); end
    checks++;
    if (bus.BUSY_OUT !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY_OUT); end
    rst = 1'b0;
  endtask

  task automatic test_heartbeat();
    logic exp;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      exp = ((edge_n / 12) % 2) == 1;
      checks++;
      if (bus.LED_OUT !== exp) begin
        errors++;
        $display("FAIL heartbeat_led cyc%0d: got %b want %b", edge_n, bus.LED_OUT, exp);
      end
      checks++;
      if (bus.GNT_OUT !== 4'b0000 || bus.BUSY_OUT !== 1'b0) begin
        errors++;
        $display("FAIL heartbeat_idle cyc%0d: got gnt=%b busy=%b want 0000/0", edge_n, bus.GNT_OUT, bus.BUSY_OUT);
      end
    end
  endtask

  task automatic test_single_pulse();
    int  t0;
    int  m;
    bit  found;
    found = 0;
    for (int w = 0; w < 8 && !found; w++) begin
      @(negedge clk);
      if (edge_n % 4 == 3) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL single_align: got no tick alignment want alignment"); return; end
    bus.REQ_IN = 4'b0100;
    @(negedge clk);
    t0 = edge_n;
    bus.REQ_IN = 4'b0000;
    for (m = 0; m < 48; m++) begin
      checks++;
      if (bus.GNT_OUT !== ((m < 44) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL single_gnt m%0d: got %b want %b", m, bus.GNT_OUT, (m < 44) ? 4'b0100 : 4'b0000);
      end
      checks++;
      if (bus.BUSY_OUT !== (m < 44)) begin
        errors++;
        $display("FAIL single_busy m%0d: got %b want %b", m, bus.BUSY_OUT, m < 44);
      end
      checks++;
      if (bus.LED_OUT !== exp_led(m, 3)) begin
        errors++;
        $display("FAIL single_led m%0d: got %b want %b", m, bus.LED_OUT, exp_led(m, 3));
      end
      @(negedge clk);
      if (edge_n - t0 != m + 1) begin
        checks++;
        errors++;
        $display("FAIL single_timebase: got %0d want %0d", edge_n - t0, m + 1);
      end
    end
  endtask

  task automatic run_code(input logic [3:0] exp_gnt, input int exp_pulses,
                          input logic [3:0] req_during, input string name);
    bit   got;
    bit   done;
    logic prev;
    int   cnt;
    got = 0;
    for (int w = 0; w < 100 && !got; w++) begin
      if (bus.GNT_OUT !== 4'b0000) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin errors++; $display("FAIL %s_grant_wait: got no grant want %b", name, exp_gnt); return; end
    checks++;
    if (bus.GNT_OUT !== exp_gnt) begin
      errors++;
      $display("FAIL %s_grant: got %b want %b", name, bus.GNT_OUT, exp_gnt);
    end
    bus.REQ_IN = req_during;
    prev = 1'b0;
    cnt  = 0;
    done = 0;
    for (int w = 0; w < 200 && !done; w++) begin
      if (bus.GNT_OUT === 4'b0000) begin
        done = 1;
      end else begin
        if (bus.LED_OUT === 1'b1 && prev === 1'b0) cnt++;
        prev = bus.LED_OUT;
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL %s_code_end: got grant stuck want release", name); end
    checks++;
    if (cnt != exp_pulses) begin
      errors++;
      $display("FAIL %s_pulses: got %0d want %0d", name, cnt, exp_pulses);
    end
  endtask

  task automatic test_all_held();
    apply_reset();
    bus.REQ_IN = 4'b1111;
    run_code(4'b0001, 1, 4'b1111, "rr0");
    run_code(4'b0010, 2, 4'b1111, "rr1");
    run_code(4'b0100, 3, 4'b1111, "rr2");
    run_code(4'b1000, 4, 4'b1111, "rr3");
    run_code(4'b0001, 1, 4'b0000, "rr4");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.REQ_IN = 4'b0001;
    run_code(4'b0001, 1, 4'b1001, "b2b0");
    run_code(4'b1000, 4, 4'b1001, "b2b1");
    run_code(4'b0001, 1, 4'b0000, "b2b2");
  endtask

  task automatic test_reset_mid_code();
    bit got;
    bit bad;
    apply_reset();
    bus.REQ_IN = 4'b0001;
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (bus.GNT_OUT !== 4'b0000) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL midrst_grant_wait: got no grant want 0001"); end
    bus.REQ_IN = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus.LED_OUT !== 1'b1) begin errors++; $display("FAIL midrst_led_on: got %b want 1", bus.LED_OUT); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.LED_OUT !== 1'b0) begin errors++; $display("FAIL midrst_led: got %b want 0", bus.LED_OUT); end
    checks++;
    if (bus.GNT_OUT !== 4'b0000) begin errors++; $display("FAIL midrst_gnt: got %b want 0000", bus.GNT_OUT); end
    checks++;
    if (bus.BUSY_OUT !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.BUSY_OUT); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.GNT_OUT !== 4'b0000 || bus.BUSY_OUT !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL midrst_idle: got active after release want idle"); end
    bus.REQ_IN = 4'b0010;
    run_code(4'b0010, 2, 4'b0000, "midrst_restart");
  endtask

`ifdef PRT_LED_CTL_PWM_EN
  task automatic test_pwm_dark();
    bit lit;
    apply_reset();
    bus.DIM_IN = 8'd0;
    bus.REQ_IN = 4'b1000;
    lit = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.LED_OUT !== 1'b0) lit = 1;
    end
    bus.REQ_IN = 4'b0000;
    checks++;
    if (lit) begin errors++; $display("FAIL pwm_dim0: got led high want led low"); end
    bus.DIM_IN = 8'd255;
  endtask
`endif

  initial begin
    bus.REQ_IN = 4'b0000;
`ifdef PRT_LED_CTL_PWM_EN
    bus.DIM_IN = 8'd255;
`endif
    test_reset();
    test_heartbeat();
    test_single_pulse();
    test_all_held();
    test_back_to_back();
    test_reset_mid_code();
`ifdef PRT_LED_CTL_PWM_EN
    test_pwm_dark();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
